// File: rtl/block_osc_pkg.sv
// block_osc_pkg: shared state encoding, direction constants and default bounds for the block mover.
package block_osc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} osc_state_e;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam int DEF_X_MIN = 0;
    localparam int DEF_X_MAX = 144;
endpackage

// File: rtl/block_oscillator_if.sv
// block_oscillator_if: control inputs and position/handshake outputs of block_oscillator.
interface block_oscillator_if #(
    parameter int POS_W  = 8,
    parameter int STEP_W = 3,
    parameter int DIV_W  = 4
);
    logic              sync;
    logic              enable;
    logic              start;
    logic              freeze;
    logic [STEP_W-1:0] step;
    logic [DIV_W-1:0]  div;
    logic [POS_W-1:0]  curr_x_position;
    logic              direction;
    logic              running;
    logic [POS_W-1:0]  frozen_x;
    logic              frozen_valid;
    logic              bounce;
    modport master (
        output sync, enable, start, freeze, step, div,
        input  curr_x_position, direction, running, frozen_x, frozen_valid, bounce
    );
    modport slave (
        input  sync, enable, start, freeze, step, div,
        output curr_x_position, direction, running, frozen_x, frozen_valid, bounce
    );
endinterface

// File: rtl/block_oscillator_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus one-cycle rising-edge pulse for asynchronous strobes.
module sync_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic i_async,
    output logic o_pulse
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end
    assign o_pulse = r_sync & ~r_prev;
endmodule

// File: rtl/block_oscillator.sv
// block_oscillator: parametrised ping-pong mover with divider and freeze/capture handshake.
// Define BLOCK_OSC_WRAP_EN to wrap around the bounds instead of bouncing.
module block_oscillator
    import block_osc_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int X_MIN   = DEF_X_MIN,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int X_START = 0,
    parameter int STEP_W  = 3,
    parameter int DIV_W   = 4
) (
    input  logic               clk,
    input  logic               resetn,
    block_oscillator_if.slave  bus
);
    localparam int EW = POS_W + 1;
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]       r_state;
    logic [POS_W-1:0] r_pos, r_frozen_x;
    logic             r_dir, r_frozen_valid, r_bounce;
    logic [DIV_W-1:0] r_cnt;

    logic              w_tick, w_run, w_cap, w_adv, w_due, w_move, w_hit;
    logic [STEP_W-1:0] w_step;
    logic [DIV_W-1:0]  w_div;
    logic [POS_W:0]    w_pos_ext, w_step_ext, w_sum, w_lo;
    logic [POS_W-1:0]  w_next_pos;
    logic              w_next_dir;

    sync_edge_detect u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (bus.sync),
        .o_pulse (w_tick)
    );

    assign w_step     = bus.step;
    assign w_div      = bus.div;
    assign w_run      = r_state == S_RUN;
    assign w_cap      = w_run & bus.freeze;
    assign w_adv      = w_run & w_tick & bus.enable & ~bus.freeze & ~bus.start;
    assign w_due      = r_cnt >= w_div;
    assign w_move     = w_adv & w_due & (w_step != '0);
    assign w_pos_ext  = {1'b0, r_pos};
    assign w_step_ext = EW'(w_step);
    assign w_sum      = w_pos_ext + w_step_ext;
    assign w_lo       = EW'(X_MIN) + w_step_ext;

`ifdef BLOCK_OSC_WRAP_EN
    always_comb begin
        w_hit      = r_dir ? (w_sum > EW'(X_MAX)) : (w_pos_ext < w_lo);
        w_next_dir = r_dir;
        w_next_pos = w_hit ? (r_dir ? POS_W'(X_MIN) : POS_W'(X_MAX))
                   : (r_dir ? w_sum[POS_W-1:0] : r_pos - POS_W'(w_step));
    end
`else
    // Comparisons include equality so the block stops exactly on the bound.
    always_comb begin
        w_hit      = r_dir ? (w_sum >= EW'(X_MAX)) : (w_pos_ext <= w_lo);
        w_next_dir = w_hit ? ~r_dir : r_dir;
        w_next_pos = w_hit ? (r_dir ? POS_W'(X_MAX) : POS_W'(X_MIN))
                   : (r_dir ? w_sum[POS_W-1:0] : r_pos - POS_W'(w_step));
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_pos          <= POS_W'(X_START);
            r_dir          <= DIR_RIGHT;
            r_cnt          <= '0;
            r_frozen_x     <= '0;
            r_frozen_valid <= 1'b0;
            r_bounce       <= 1'b0;
        end else begin
            r_frozen_valid <= 1'b0;
            r_bounce       <= 1'b0;
            if (w_cap) begin
                r_frozen_x     <= r_pos;
                r_frozen_valid <= 1'b1;
                r_state        <= S_HOLD;
            end else if (bus.start) begin
                r_pos   <= POS_W'(X_START);
                r_dir   <= DIR_RIGHT;
                r_cnt   <= '0;
                r_state <= S_RUN;
            end else if (w_adv) begin
                r_cnt <= w_due ? '0 : r_cnt + DIV_W'(1);
                if (w_move) begin
                    r_pos    <= w_next_pos;
                    r_dir    <= w_next_dir;
                    r_bounce <= w_hit;
                end
            end
        end
    end

    assign bus.curr_x_position = r_pos;
    assign bus.direction       = r_dir;
    assign bus.running         = w_run;
    assign bus.frozen_x        = r_frozen_x;
    assign bus.frozen_valid    = r_frozen_valid;
    assign bus.bounce          = r_bounce;
endmodule

// File: tb/tb_block_oscillator.sv
// tb_block_oscillator: directed self-checking bench for block_oscillator in its default (bounce) build.
module tb_block_oscillator;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_bounce = 0;
    int   b0;

    block_oscillator_if bus ();

    block_oscillator dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.bounce) n_bounce <= n_bounce + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        bus.sync = 1'b1;
        repeat (3) @(negedge clk);
        bus.sync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.sync = 1'b0; bus.enable = 1'b1; bus.start = 1'b0; bus.freeze = 1'b0;
        bus.step = 3'd1; bus.div = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_pos", int'(bus.curr_x_position), 0);
        chk("rst_dir", int'(bus.direction), 1);
        chk("rst_run", int'(bus.running), 0);
        chk("rst_fx", int'(bus.frozen_x), 0);
        chk("rst_fv", int'(bus.frozen_valid), 0);
        chk("rst_bnc", int'(bus.bounce), 0);
        resetn = 1'b1;
        @(negedge clk);
        do_tick();
        chk("idle_static", int'(bus.curr_x_position), 0);

        pulse_start();
        chk("start_run", int'(bus.running), 1);
        b0 = n_bounce;
        ticks(143);
        chk("pos143", int'(bus.curr_x_position), 143);
        chk("dir143", int'(bus.direction), 1);
        do_tick();
        chk("pos144", int'(bus.curr_x_position), 144);
        chk("dir144", int'(bus.direction), 0);
        chk("bounce_once", n_bounce - b0, 1);
        do_tick();
        chk("pos145", int'(bus.curr_x_position), 143);

        pulse_start();
        bus.step = 3'd2;
        ticks(71);
        chk("pos142", int'(bus.curr_x_position), 142);
        bus.step = 3'd5;
        b0 = n_bounce;
        do_tick();
        chk("s5_pos144", int'(bus.curr_x_position), 144);
        chk("s5_dir", int'(bus.direction), 0);
        chk("s5_bnc", n_bounce - b0, 1);
        do_tick();
        chk("s5_pos139", int'(bus.curr_x_position), 139);
        bus.step = 3'd0;
        b0 = n_bounce;
        ticks(2);
        chk("step0_pos", int'(bus.curr_x_position), 139);
        chk("step0_bnc", n_bounce - b0, 0);

        bus.step = 3'd1; bus.div = 4'd2;
        pulse_start();
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            chk($sformatf("div2_t%0d", k), int'(bus.curr_x_position), k / 3);
        end

        bus.div = 4'd0;
        pulse_start();
        ticks(37);
        chk("pre_frz", int'(bus.curr_x_position), 37);
        bus.freeze = 1'b1;
        bus.sync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.freeze = 1'b0;
        chk("frz_fv", int'(bus.frozen_valid), 0);
        bus.sync = 1'b0;
        repeat (3) @(negedge clk);
        chk("frz_nomove", int'(bus.curr_x_position), 37);
        bus.sync = 1'b0;
        bus.freeze = 1'b1;
        @(negedge clk);
        bus.freeze = 1'b0;
        chk("frz_fv_hold", int'(bus.frozen_valid), 0);
        pulse_start();
        ticks(37);
        bus.freeze = 1'b1;
        @(negedge clk);
        bus.freeze = 1'b0;
        chk("frz_fv1", int'(bus.frozen_valid), 1);
        chk("frz_fx", int'(bus.frozen_x), 37);
        chk("frz_run", int'(bus.running), 0);
        @(negedge clk);
        chk("frz_fv0", int'(bus.frozen_valid), 0);
        ticks(5);
        chk("hold_pos", int'(bus.curr_x_position), 37);
        chk("hold_fx", int'(bus.frozen_x), 37);
        pulse_start();
        chk("restart_pos", int'(bus.curr_x_position), 0);
        chk("restart_run", int'(bus.running), 1);

        ticks(10);
        bus.start = 1'b1; bus.freeze = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.freeze = 1'b0;
        chk("sf_fx", int'(bus.frozen_x), 10);
        chk("sf_run", int'(bus.running), 0);
        chk("sf_pos", int'(bus.curr_x_position), 10);

        bus.div = 4'd1;
        pulse_start();
        ticks(41);
        chk("en_pos20", int'(bus.curr_x_position), 20);
        bus.enable = 1'b0;
        ticks(10);
        chk("en_low_pos", int'(bus.curr_x_position), 20);
        bus.enable = 1'b1;
        do_tick();
        chk("en_cnt_kept", int'(bus.curr_x_position), 21);

        bus.div = 4'd0;
        bus.sync = 1'b1;
        repeat (20) @(negedge clk);
        bus.sync = 1'b0;
        repeat (3) @(negedge clk);
        chk("long_sync", int'(bus.curr_x_position), 22);
        ticks(58);
        chk("pos80", int'(bus.curr_x_position), 80);

        bus.sync = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mrst_pos", int'(bus.curr_x_position), 0);
        chk("mrst_run", int'(bus.running), 0);
        chk("mrst_dir", int'(bus.direction), 1);
        chk("mrst_fx", int'(bus.frozen_x), 0);
        chk("mrst_bnc", int'(bus.bounce), 0);
        chk("mrst_fv", int'(bus.frozen_valid), 0);
        bus.sync = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        ticks(3);
        chk("mrst_idle", int'(bus.curr_x_position), 0);
        chk("mrst_idle_run", int'(bus.running), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
